spi_bus_arbiter: RTL and testbench
==================================

// Module: spi_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single SPI memory controller (Wishbone slave: 24-bit byte address, 8-bit data)
//  between NUM_REQ Wishbone requesters (e.g. host loader, compute engine, debug port). Sits directly in front of the
//  controller; grants bus ownership per Wishbone cycle (cyc_i held = lock) and guarantees an idle gap between owners.
// PARAMETERS
//  NUM_REQ         3    number of requester ports (2..8)
//  ADDR_W          24   address width forwarded to the controller
//  DATA_W          8    data width
//  TIMEOUT_CYCLES  255  stall limit per strobe, used only with SPI_ARB_TIMEOUT_EN (must be > 90)
// PORTS
//  clk_i         in   1               clock
//  rst_ni        in   1               asynchronous reset, active low
//  req_cyc_i     in   NUM_REQ         per-requester Wishbone cycle
//  req_stb_i     in   NUM_REQ         per-requester strobe
//  req_we_i      in   NUM_REQ         per-requester write enable
//  req_adr_i     in   NUM_REQ*ADDR_W  packed addresses, requester r at [r*ADDR_W +: ADDR_W]
//  req_dat_i     in   NUM_REQ*DATA_W  packed write data
//  req_ack_o     out  NUM_REQ         ack, only the granted bit can be set
//  req_err_o     out  NUM_REQ         error, only the granted bit can be set
//  req_rty_o     out  NUM_REQ         retry, only the granted bit can be set
//  req_dat_o     out  DATA_W          read data, broadcast (= m_dat_i)
//  m_cyc_o/m_stb_o/m_we_o  out  1     to controller
//  m_adr_o       out  ADDR_W          to controller
//  m_dat_o       out  DATA_W          to controller
//  m_ack_i/m_err_i/m_rty_i in 1       from controller
//  m_dat_i       in   DATA_W          from controller
//  grant_o       out  NUM_REQ         registered one-hot current owner, 0 when idle
// BEHAVIOUR
//  - Reset: state IDLE, grant_o=0, rr pointer last=NUM_REQ-1 (requester 0 wins first); all outputs 0.
//  - States: IDLE, OWNED (+ ABORT with macro). All state/grant/pointer flops are registered.
//  - IDLE: m_cyc_o=m_stb_o=0. If any req_cyc_i, pick first set bit searching last+1, last+2, ... (wrapping);
//    next cycle: OWNED, grant_o=onehot(g), last<=g. Arbitration latency = 1 cycle after cyc seen.
//  - OWNED: combinational forward: m_cyc_o=req_cyc_i[g], m_stb_o=req_cyc_i[g]&req_stb_i[g], adr/we/dat from slice g;
//    req_ack_o[g]=m_ack_i, err/rty likewise; non-granted ack/err/rty = 0.
//  - Release: req_cyc_i[g]=0 in OWNED -> IDLE next cycle, grant_o=0. m_cyc_o is therefore low for >=2 cycles
//    between owners (controller resets its bit counter and deasserts ss_n). Earliest new grant = release+2.
//  - Multiple strobes under one held cyc are forwarded back-to-back (lock); no pre-emption.
//  - Requester drops cyc before ack (abort): forwarded immediately; controller aborts; normal release.
//  - Simultaneous requests: strict round-robin; requester just served is lowest priority.
//  - Non-granted requesters see no ack/err/rty and may hold cyc indefinitely without affecting the owner.
//  - Async reset mid-transfer: m_cyc_o drops combinationally as state goes IDLE; no ack is produced.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined: counter (clog2(TIMEOUT_CYCLES+1) bits) increments each OWNED cycle with m_stb_o=1 and
//   m_ack_i=0; cleared on ack, on stb low and on leaving OWNED. At count==TIMEOUT_CYCLES -> ABORT next cycle:
//   m_cyc_o=m_stb_o=0, req_err_o[g]=1 held until req_cyc_i[g]=0, then IDLE. m_err_i still forwarded in OWNED.
//  Not defined: no counter, no ABORT state; req_err_o[g]=m_err_i only.
// STRUCTURE
//  spi_arb_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_OWNED, ARB_ABORT} arb_state_t; localparams SPI_ADDR_W=24,
//   SPI_DATA_W=8, SPI_XFER_CYCLES=81 (min controller transaction, used by benches and TIMEOUT bound).
//  Sub-module spi_arb_rr_pick: combinational, inputs req[NUM_REQ], last index; outputs valid, one-hot and index.
// TESTING
//  1 Reset then req0 read adr 0x000010 -> grant_o=001 one cycle after cyc, ack after ~81 cycles, req_dat_o=byte.
//  2 req0,req1,req2 all raise cyc same cycle, each releases after one ack -> grant order 0,1,2, m_cyc_o low >=2 cycles
//    between each; then req0 again while req2 releases and req1 idle -> req0 granted.
//  3 req1 holds cyc over two writes (0x0000AA->0x000100, 0x55->0x000101) while req0 requests -> req0 waits; both bytes
//    read back correctly afterwards.
//  4 req2 drops cyc at cycle 20 of a transfer -> m_cyc_o low same cycle, no req_ack_o, controller ss_n high; next
//    requester granted at release+2.
//  5 Model slave never acks, SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100 -> req_err_o[g]=1 at stall cycle 101, held until
//    cyc drops; without macro -> no err, grant held.
//  6 rst_ni pulsed low mid-transfer -> grant_o=0, m_cyc_o=0 immediately; after release req0 has first priority.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI memory-controller bus arbiter.
// Optional stall timeout is enabled with the SPI_ARB_TIMEOUT_EN macro.
package spi_arb_pkg;

  localparam int unsigned SPI_ADDR_W      = 24;
  localparam int unsigned SPI_DATA_W      = 8;
  localparam int unsigned SPI_XFER_CYCLES = 81;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWNED,
    ARB_ABORT
  } arb_state_t;

  // Width of an index into n requesters (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Requester-side and controller-side Wishbone signals of the SPI bus arbiter.
// slave = arbiter view, master = view of the surrounding requesters/controller.
interface spi_bus_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = SPI_ADDR_W,
  parameter int unsigned DATA_W  = SPI_DATA_W
);

  logic [NUM_REQ-1:0]        req_cyc_i;
  logic [NUM_REQ-1:0]        req_stb_i;
  logic [NUM_REQ-1:0]        req_we_i;
  logic [NUM_REQ*ADDR_W-1:0] req_adr_i;
  logic [NUM_REQ*DATA_W-1:0] req_dat_i;
  logic [NUM_REQ-1:0]        req_ack_o;
  logic [NUM_REQ-1:0]        req_err_o;
  logic [NUM_REQ-1:0]        req_rty_o;
  logic [DATA_W-1:0]         req_dat_o;

  logic                      m_cyc_o;
  logic                      m_stb_o;
  logic                      m_we_o;
  logic [ADDR_W-1:0]         m_adr_o;
  logic [DATA_W-1:0]         m_dat_o;
  logic                      m_ack_i;
  logic                      m_err_i;
  logic                      m_rty_i;
  logic [DATA_W-1:0]         m_dat_i;

  logic [NUM_REQ-1:0]        grant_o;

  modport slave (
    input  req_cyc_i, req_stb_i, req_we_i, req_adr_i, req_dat_i,
    input  m_ack_i, m_err_i, m_rty_i, m_dat_i,
    output req_ack_o, req_err_o, req_rty_o, req_dat_o,
    output m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o,
    output grant_o
  );

  modport master (
    output req_cyc_i, req_stb_i, req_we_i, req_adr_i, req_dat_i,
    output m_ack_i, m_err_i, m_rty_i, m_dat_i,
    input  req_ack_o, req_err_o, req_rty_o, req_dat_o,
    input  m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o,
    input  grant_o
  );

endinterface

// File: rtl/spi_arb_rr_pick.sv
// Round-robin picker: first requester after 'last', wrapping, so the
// requester served most recently has the lowest priority.
module spi_arb_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (!valid && req[r] && (r == ((32'(last) + i) % NUM_REQ))) begin
          valid     = 1'b1;
          onehot[r] = 1'b1;
          idx       = IDX_W'(r);
        end
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI memory controller among NUM_REQ Wishbone
// requesters; ownership lasts a whole cyc. Macro SPI_ARB_TIMEOUT_EN adds a stall timeout.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned ADDR_W         = SPI_ADDR_W,
  parameter int unsigned DATA_W         = SPI_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk_i,
  input logic              rst_ni,
  spi_bus_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  arb_state_t         state;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   last;
  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_cyc;
  logic               owned;
  logic               timeout;

  spi_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (bus.req_cyc_i),
    .last   (last),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign owner_cyc   = |(bus.req_cyc_i & grant);
  assign owned       = (state == ARB_OWNED);
  assign bus.grant_o = grant;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] stall_cnt;

  assign timeout = (stall_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Counts consecutive unacknowledged strobe cycles of the current owner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (owned && bus.m_stb_o && !bus.m_ack_i) begin
      if (!timeout) stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      stall_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ARB_IDLE;
      grant <= '0;
      last  <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state <= ARB_OWNED;
            grant <= pick_onehot;
            last  <= pick_idx;
          end
        end
        ARB_OWNED: begin
          if (!owner_cyc) begin
            state <= ARB_IDLE;
            grant <= '0;
          end else if (timeout && !bus.m_ack_i) begin
            state <= ARB_ABORT;
          end
        end
        ARB_ABORT: begin
          if (!owner_cyc) begin
            state <= ARB_IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= ARB_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Owner's request is forwarded straight through; the bus is quiet otherwise.
  always_comb begin
    bus.m_cyc_o = 1'b0;
    bus.m_stb_o = 1'b0;
    bus.m_we_o  = 1'b0;
    bus.m_adr_o = '0;
    bus.m_dat_o = '0;
    if (owned) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (grant[r]) begin
          bus.m_cyc_o = bus.req_cyc_i[r];
          bus.m_stb_o = bus.req_cyc_i[r] & bus.req_stb_i[r];
          bus.m_we_o  = bus.req_we_i[r];
          bus.m_adr_o = bus.req_adr_i[r*ADDR_W +: ADDR_W];
          bus.m_dat_o = bus.req_dat_i[r*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    bus.req_ack_o = '0;
    bus.req_err_o = '0;
    bus.req_rty_o = '0;
    if (owned) begin
      bus.req_ack_o = grant & {NUM_REQ{bus.m_ack_i}};
      bus.req_err_o = grant & {NUM_REQ{bus.m_err_i}};
      bus.req_rty_o = grant & {NUM_REQ{bus.m_rty_i}};
    end else if (state == ARB_ABORT) begin
      bus.req_err_o = grant;
    end
  end

  assign bus.req_dat_o = bus.m_dat_i;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a behavioural SPI controller model.
// Build with SPI_ARB_TIMEOUT_EN defined to exercise the stall timeout path.
module tb_spi_bus_arbiter;
  import spi_arb_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_bus_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  spi_bus_arbiter #(
    .NUM_REQ        (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Controller model: acks on the 81st strobe cycle; mem[i] preset to i ^ 0x5A.
  logic [7:0] mem [0:1023];
  int         cnt;
  logic       ss_n;
  bit         noack = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_ack_i <= 1'b0;
      bus.m_err_i <= 1'b0;
      bus.m_rty_i <= 1'b0;
      bus.m_dat_i <= '0;
      cnt         <= 0;
      ss_n        <= 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (!bus.m_cyc_o) begin
      cnt         <= 0;
      bus.m_ack_i <= 1'b0;
      ss_n        <= 1'b1;
    end else begin
      ss_n        <= 1'b0;
      bus.m_ack_i <= 1'b0;
      if (bus.m_stb_o && !bus.m_ack_i && !noack) begin
        if (cnt == int'(SPI_XFER_CYCLES) - 1) begin
          cnt         <= 0;
          bus.m_ack_i <= 1'b1;
          if (bus.m_we_o) mem[bus.m_adr_o[9:0]] <= bus.m_dat_o;
          else            bus.m_dat_i <= mem[bus.m_adr_o[9:0]];
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic we, input logic [23:0] adr, input logic [7:0] dat);
    bus.req_cyc_i[r]           = 1'b1;
    bus.req_stb_i[r]           = 1'b1;
    bus.req_we_i[r]            = we;
    bus.req_adr_i[r*AW +: AW]  = adr;
    bus.req_dat_i[r*DW +: DW]  = dat;
  endtask

  task automatic drop_req(input int r);
    bus.req_cyc_i[r] = 1'b0;
    bus.req_stb_i[r] = 1'b0;
    bus.req_we_i[r]  = 1'b0;
  endtask

  task automatic wait_grant(input int r, output int n);
    logic [N-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    n = -1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (bus.grant_o === oh) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int r, output int n, output logic [7:0] d);
    n = -1;
    d = 'x;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (bus.req_ack_o[r] === 1'b1) begin
        n = i;
        d = bus.req_dat_o;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [7:0] d;
    int         order [3];
    logic [7:0] exp_rd [3];
    bit         bad;

    order  = '{0, 1, 2};
    exp_rd = '{8'h7A, 8'h7B, 8'h78};

    bus.req_cyc_i = '0;
    bus.req_stb_i = '0;
    bus.req_we_i  = '0;
    bus.req_adr_i = '0;
    bus.req_dat_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(bus.grant_o), 0);
    chk("rst_m_cyc", 32'(bus.m_cyc_o), 0);
    chk("rst_m_stb", 32'(bus.m_stb_o), 0);
    chk("rst_ack",   32'(bus.req_ack_o), 0);
    chk("rst_err",   32'(bus.req_err_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_grant", 32'(bus.grant_o), 0);

    // Single read by requester 0
    set_req(0, 1'b0, 24'h000010, 8'h00);
    wait_grant(0, n);
    chk("t1_grant_lat", n, 1);
    chk("t1_m_cyc", 32'(bus.m_cyc_o), 1);
    chk("t1_m_adr", 32'(bus.m_adr_o), 32'h10);
    wait_ack(0, n, d);
    chk("t1_ack_lat", n, 81);
    chk("t1_rdata", 32'(d), 32'h4A);
    drop_req(0);
    #1 chk("t1_rel_m_cyc", 32'(bus.m_cyc_o), 0);
    @(negedge clk);
    chk("t1_rel_grant", 32'(bus.grant_o), 0);

    // Three simultaneous requesters after a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 1'b0, 24'h000020, 8'h00);
    set_req(1, 1'b0, 24'h000021, 8'h00);
    set_req(2, 1'b0, 24'h000022, 8'h00);
    for (int k = 0; k < 3; k++) begin
      wait_grant(order[k], n);
      if (k == 0) chk("t2_first_lat", n, 1);
      else        chk("t2_gap", n, 2);
      wait_ack(order[k], n, d);
      chk("t2_rdata", 32'(d), 32'(exp_rd[k]));
      drop_req(order[k]);
      if (k == 2) set_req(0, 1'b0, 24'h000023, 8'h00);
      #1 chk("t2_rel_m_cyc", 32'(bus.m_cyc_o), 0);
    end
    wait_grant(0, n);
    chk("t2_req0_again", n, 2);
    wait_ack(0, n, d);
    chk("t2_req0_rdata", 32'(d), 32'h79);
    drop_req(0);
    @(negedge clk);

    // Locked two-write cycle by requester 1, requester 0 waits
    set_req(1, 1'b1, 24'h000100, 8'hAA);
    wait_grant(1, n);
    chk("t3_grant_lat", n, 1);
    set_req(0, 1'b0, 24'h000100, 8'h00);
    wait_ack(1, n, d);
    chk("t3_wr1_lat", n, 81);
    chk("t3_ack_onehot", 32'(bus.req_ack_o), 32'b010);
    set_req(1, 1'b1, 24'h000101, 8'h55);
    chk("t3_lock_grant", 32'(bus.grant_o), 32'b010);
    wait_ack(1, n, d);
    chk("t3_wr2_lat", n, 82);
    drop_req(1);
    wait_grant(0, n);
    chk("t3_req0_gap", n, 2);
    wait_ack(0, n, d);
    chk("t3_rd_100", 32'(d), 32'hAA);
    set_req(0, 1'b0, 24'h000101, 8'h00);
    wait_ack(0, n, d);
    chk("t3_rd_101", 32'(d), 32'h55);
    drop_req(0);
    @(negedge clk);

    // Requester 2 aborts mid-transfer; requester 1 queued behind it
    set_req(2, 1'b0, 24'h000030, 8'h00);
    wait_grant(2, n);
    chk("t4_grant_lat", n, 1);
    bad = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) set_req(1, 1'b0, 24'h000031, 8'h00);
      if (bus.req_ack_o !== '0) bad = 1'b1;
    end
    chk("t4_ss_active", 32'(ss_n), 0);
    drop_req(2);
    #1 chk("t4_abort_m_cyc", 32'(bus.m_cyc_o), 0);
    chk("t4_no_ack", 32'(bad), 0);
    @(negedge clk);
    chk("t4_ss_high", 32'(ss_n), 1);
    chk("t4_idle_grant", 32'(bus.grant_o), 0);
    wait_grant(1, n);
    chk("t4_next_grant", n, 1);
    wait_ack(1, n, d);
    chk("t4_req1_lat", n, 81);
    chk("t4_req1_rdata", 32'(d), 32'h6B);
    drop_req(1);
    @(negedge clk);

    // Controller never acks
    noack = 1'b1;
    set_req(0, 1'b0, 24'h000040, 8'h00);
    wait_grant(0, n);
    chk("t5_grant_lat", n, 1);
`ifdef SPI_ARB_TIMEOUT_EN
    n = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (bus.req_err_o[0] === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("t5_timeout_at", n, 101);
    chk("t5_abort_m_cyc", 32'(bus.m_cyc_o), 0);
    repeat (5) @(negedge clk);
    chk("t5_err_held", 32'(bus.req_err_o), 32'b001);
    drop_req(0);
    @(negedge clk);
    chk("t5_err_clear", 32'(bus.req_err_o), 0);
    chk("t5_rel_grant", 32'(bus.grant_o), 0);
`else
    bad = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (bus.req_err_o !== '0) bad = 1'b1;
    end
    chk("t5_no_err", 32'(bad), 0);
    chk("t5_grant_held", 32'(bus.grant_o), 32'b001);
    chk("t5_m_cyc_held", 32'(bus.m_cyc_o), 1);
    drop_req(0);
    @(negedge clk);
    chk("t5_rel_grant", 32'(bus.grant_o), 0);
`endif
    noack = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of requester 1's transfer
    set_req(1, 1'b0, 24'h000050, 8'h00);
    wait_grant(1, n);
    chk("t6_grant_lat", n, 1);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("t6_rst_grant", 32'(bus.grant_o), 0);
    chk("t6_rst_m_cyc", 32'(bus.m_cyc_o), 0);
    set_req(0, 1'b0, 24'h000051, 8'h00);
    @(negedge clk);
    chk("t6_rst_ack", 32'(bus.req_ack_o), 0);
    rst_n = 1'b1;
    wait_grant(0, n);
    chk("t6_req0_first", n, 1);
    wait_ack(0, n, d);
    chk("t6_req0_rdata", 32'(d), 32'h0B);
    drop_req(0);
    wait_grant(1, n);
    chk("t6_req1_next", n, 2);
    wait_ack(1, n, d);
    chk("t6_req1_rdata", 32'(d), 32'h0A);
    drop_req(1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
